// File: rtl/dual_slope_datapath_if.sv
`default_nettype none
// ============================================================================
//  Module      : dual_slope_datapath_if
//  Description : Control, data and status bundle between the dual-slope
//                conversion controller (master) and the datapath (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface dual_slope_datapath_if;
    logic        enb_0;
    logic        rst_s;
    logic        ch_vm;
    logic        ch_ref;
    logic        ch_zr;
    logic        ld;
    logic [7:0]  vin;
    logic [7:0]  vref;
    logic        enb_3;
    logic        Vint_z;
    logic [11:0] count;
    logic [11:0] result;
    logic        overflow;

    modport master (
        output enb_0, rst_s, ch_vm, ch_ref, ch_zr, ld, vin, vref,
        input  enb_3, Vint_z, count, result, overflow
    );

    modport slave (
        input  enb_0, rst_s, ch_vm, ch_ref, ch_zr, ld, vin, vref,
        output enb_3, Vint_z, count, result, overflow
    );
endinterface
`default_nettype wire

// File: rtl/dual_slope_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : dual_slope_datapath
//  Description : Dual-slope ADC datapath: 18-bit integrator, 3-digit BCD
//                counter with wrap pulse, and falling-edge result latch.
//                Optional macro DS_OVERFLOW_EN adds sticky discharge overflow.
//  Revision    : 1.0  initial release
// ============================================================================
module dual_slope_datapath (
    input  wire logic            ck,
    input  wire logic            rst,
    dual_slope_datapath_if.slave bus
);
    localparam int          c_ACC_W   = 18;
    localparam int          c_DIGITS  = 3;
    localparam logic [11:0] c_BCD_MAX = 12'h999;

    logic [c_ACC_W-1:0] r_acc;
    logic [c_ACC_W-1:0] w_acc_nxt;
    logic [c_ACC_W-1:0] w_vin_ext;
    logic [c_ACC_W-1:0] w_vref_ext;
    logic               w_acc_zero;

    logic [11:0]        r_count;
    logic [11:0]        w_count_inc;
    logic [11:0]        w_count_nxt;
    logic [c_DIGITS:0]  w_carry;

    logic               w_ref_eff;
    logic               w_inc;
    logic               w_wrap;
    logic               r_enb_3;

    logic               r_ld_d;
    logic               w_ld_fall;
    logic [11:0]        r_result;
    logic [11:0]        w_load_val;
    logic               w_overflow;

    // ------------------------------------------------------------------
    // Integrator
    // ------------------------------------------------------------------
    assign w_vin_ext  = {{(c_ACC_W-8){1'b0}}, bus.vin};
    assign w_vref_ext = {{(c_ACC_W-8){1'b0}}, bus.vref};
    assign w_acc_zero = (r_acc == '0);

    always_comb begin
        w_acc_nxt = r_acc;
        if (bus.ch_zr) begin
            w_acc_nxt = '0;
        end else if (bus.ch_vm && bus.enb_0) begin
            w_acc_nxt = r_acc + w_vin_ext;
        end else if (bus.ch_ref && bus.enb_0 && !w_acc_zero) begin
            w_acc_nxt = (r_acc > w_vref_ext) ? (r_acc - w_vref_ext) : '0;
        end
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_acc_nxt;
        end
    end

    // ------------------------------------------------------------------
    // BCD counter; integrate-phase (ch_vm) overrides the reference stop
    // ------------------------------------------------------------------
    assign w_ref_eff = bus.ch_ref && !bus.ch_vm;
    assign w_inc     = bus.enb_0 && !(w_ref_eff && w_acc_zero);
    assign w_carry[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < c_DIGITS; gi = gi + 1) begin : g_digit
            logic [3:0] w_d;
            assign w_d = r_count[4*gi +: 4];
            assign w_count_inc[4*gi +: 4] = !w_carry[gi]   ? w_d  :
                                            (w_d == 4'd9)  ? 4'd0 :
                                                             w_d + 4'd1;
            assign w_carry[gi+1] = w_carry[gi] && (w_d == 4'd9);
        end
    endgenerate

    assign w_wrap = !bus.rst_s && w_inc && w_carry[c_DIGITS];

    always_comb begin
        w_count_nxt = r_count;
        if (bus.rst_s) begin
            w_count_nxt = '0;
        end else if (w_inc) begin
            w_count_nxt = w_count_inc;
        end
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_enb_3 <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_enb_3 <= w_wrap;
        end
    end

    // ------------------------------------------------------------------
    // Optional sticky overflow
    // ------------------------------------------------------------------
`ifdef DS_OVERFLOW_EN
    logic r_ovf;

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (bus.rst_s || bus.ch_zr) begin
            r_ovf <= 1'b0;
        end else if (w_wrap && w_ref_eff) begin
            r_ovf <= 1'b1;
        end
    end

    assign w_overflow = r_ovf;
    assign w_load_val = r_ovf ? c_BCD_MAX : r_count;
`else
    assign w_overflow = 1'b0;
    assign w_load_val = r_count;
`endif

    // ------------------------------------------------------------------
    // Result latch on ld falling edge; uses the pre-clear count
    // ------------------------------------------------------------------
    assign w_ld_fall = r_ld_d && !bus.ld;

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_ld_d   <= 1'b0;
            r_result <= '0;
        end else begin
            r_ld_d <= bus.ld;
            if (w_ld_fall) begin
                r_result <= w_load_val;
            end
        end
    end

    assign bus.enb_3    = r_enb_3;
    assign bus.Vint_z   = w_acc_zero;
    assign bus.count    = r_count;
    assign bus.result   = r_result;
    assign bus.overflow = w_overflow;
endmodule
`default_nettype wire

// File: tb/tb_dual_slope_datapath.sv
`default_nettype none
// Testbench for dual_slope_datapath: directed conversions plus random control
// traffic, compared every cycle against an integer-level reference model.
module tb_dual_slope_datapath;
`ifdef DS_OVERFLOW_EN
    localparam bit c_OVF_EN = 1'b1;
`else
    localparam bit c_OVF_EN = 1'b0;
`endif

    logic ck;
    logic rst;
    int   checks;
    int   errors;

    dual_slope_datapath_if bus ();

    dual_slope_datapath dut (
        .ck  (ck),
        .rst (rst),
        .bus (bus)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // reference model state (plain integers)
    int m_acc;
    int m_count;
    int m_result;
    bit m_ovf;
    bit m_enb3;
    bit m_ld_d;

    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] h, t, u;
        h = 4'((v / 100) % 10);
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
        return {h, t, u};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_count = 0; m_result = 0;
        m_ovf = 0; m_enb3 = 0; m_ld_d = 0;
    endtask

    task automatic model_clock();
        bit ref_eff, inc, wrap, ld_fall;
        int n_acc;
        if (rst) begin
            model_reset();
            return;
        end
        ref_eff = bus.ch_ref && !bus.ch_vm;
        inc     = bus.enb_0 && !(ref_eff && (m_acc == 0));
        wrap    = !bus.rst_s && inc && (m_count == 999);
        ld_fall = m_ld_d && !bus.ld;
        if (ld_fall)
            m_result = (c_OVF_EN && m_ovf) ? 999 : m_count;
        if (bus.ch_zr)                          n_acc = 0;
        else if (bus.ch_vm && bus.enb_0)        n_acc = m_acc + int'(bus.vin);
        else if (bus.ch_ref && bus.enb_0 && m_acc != 0)
            n_acc = (m_acc > int'(bus.vref)) ? m_acc - int'(bus.vref) : 0;
        else                                    n_acc = m_acc;
        if (bus.rst_s || bus.ch_zr) m_ovf = 0;
        else if (wrap && ref_eff)   m_ovf = 1;
        if (bus.rst_s)  m_count = 0;
        else if (inc)   m_count = (m_count + 1) % 1000;
        m_acc  = n_acc;
        m_enb3 = wrap;
        m_ld_d = bus.ld;
    endtask

    task automatic compare_all();
        check("count",    bus.count,    to_bcd(m_count));
        check("enb_3",    bus.enb_3,    m_enb3);
        check("Vint_z",   bus.Vint_z,   (m_acc == 0));
        check("result",   bus.result,   to_bcd(m_result));
        check("overflow", bus.overflow, c_OVF_EN && m_ovf);
        check("acc",      dut.r_acc,    m_acc);
    endtask

    task automatic step();
        @(posedge ck);
        model_clock();
        #1;
        compare_all();
    endtask

    task automatic drive(input bit en, input bit rs, input bit vm, input bit rf,
                         input bit zr, input bit l);
        bus.enb_0 = en; bus.rst_s = rs; bus.ch_vm = vm;
        bus.ch_ref = rf; bus.ch_zr = zr; bus.ld = l;
    endtask

    task automatic conversion(input string tag, input int vi, input int vr,
                              input int dis_cycles, input logic [11:0] exp_cnt,
                              input int exp_pulses, input logic [11:0] exp_res,
                              input bit exp_ovf);
        int pulses;
        pulses = 0;
        bus.vin  = 8'(vi);
        bus.vref = 8'(vr);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        check({tag, "_clr_enb3"}, bus.enb_3, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (1000) begin
            step();
            pulses += int'(bus.enb_3);
        end
        check({tag, "_int_acc"}, dut.r_acc, vi * 1000);
        check({tag, "_int_cnt"}, bus.count, 12'h000);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (dis_cycles) begin
            step();
            pulses += int'(bus.enb_3);
        end
        check({tag, "_freeze"}, bus.count, exp_cnt);
        check({tag, "_vz"},     bus.Vint_z, 1'b1);
        check({tag, "_pulses"}, pulses, exp_pulses);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check({tag, "_result"}, bus.result, exp_res);
        check({tag, "_ovf"},    bus.overflow, exp_ovf);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.vin  = 8'd0;
        bus.vref = 8'd1;
        model_reset();
        step();
        step();
        check("rst_count",  bus.count,  12'h000);
        check("rst_vz",     bus.Vint_z, 1'b1);
        check("rst_result", bus.result, 12'h000);
        rst = 1'b0;
        step();

        // normal conversion: 100000 / 200 = 500 counts
        conversion("conv", 100, 200, 520, 12'h500, 1, 12'h500, 1'b0);
        // rounding up: ceil(1000/3) = 334
        conversion("round", 1, 3, 340, 12'h334, 1, 12'h334, 1'b0);
        // discharge of 1250 counts wraps a second time
        conversion("ovf", 250, 200, 1270, 12'h250, 2,
                   c_OVF_EN ? 12'h999 : 12'h250, c_OVF_EN);

        // zero has priority over integrate, counter still runs
        bus.vin = 8'd77;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (3) step();
        check("prio_acc", dut.r_acc, 0);
        check("prio_cnt", bus.count, 12'h003);

        // reset mid-integration with ld high beforehand
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (30) step();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("arst_cnt",  bus.count,  12'h000);
        check("arst_acc",  dut.r_acc,  0);
        check("arst_vz",   bus.Vint_z, 1'b1);
        check("arst_enb3", bus.enb_3,  1'b0);
        check("arst_res",  bus.result, 12'h000);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) step();
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) step();
        check("arst_noload", bus.result, 12'h000);

        // randomized control traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(3, 0) != 0, $urandom_range(15, 0) == 0,
                  $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1,
                  $urandom_range(31, 0) == 0, $urandom_range(3, 0) == 0);
            bus.vin  = 8'($urandom_range(255, 0));
            bus.vref = 8'($urandom_range(255, 1));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dual_slope_datapath.md
DUAL_SLOPE_DATAPATH -- requirements
Module: dual_slope_datapath

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with the ports listed below.
- ck  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
REQ-002 It SHALL have these control inputs, driven by the conversion controller:
- enb_0  input  1  counter enable.
- rst_s  input  1  synchronous counter clear.
- ch_vm  input  1  integrate the input.
- ch_ref  input  1  de-integrate the reference.
- ch_zr  input  1  zero the integrator.
- ld  input  1  result load strobe, active on its falling edge.
REQ-003 It SHALL have these data inputs:
- vin  input  8  unsigned input magnitude.
- vref  input  8  unsigned reference magnitude, nonzero.
REQ-004 It SHALL have these status outputs to the controller:
- enb_3  output  1  one-cycle counter-wrap pulse.
- Vint_z  output  1  integrator-at-zero flag.
REQ-005 It SHALL have these data outputs:
- count  output  12  live 3-digit BCD count.
- result  output  12  latched 3-digit BCD result.
- overflow  output  1  discharge exceeded 999 counts.

Function
REQ-006 The integrator SHALL be an 18-bit unsigned register acc, updated each cycle by the first true rule:
- ch_zr: acc=0.
- ch_vm & enb_0: acc += vin.
- ch_ref & enb_0 & acc!=0: acc = acc - vref, saturating at 0.
- otherwise: acc holds.
REQ-007 Vint_z SHALL be the combinational decode acc==0.
REQ-008 The counter SHALL be three BCD digits (count[11:8] hundreds, [7:4] tens, [3:0] units), and each digit SHALL wrap 9->0 with a carry.
REQ-009 The counter SHALL be updated each cycle by the first true rule:
- rst_s: clear to 000.
- enb_0 & !(ch_ref & Vint_z): increment.
- otherwise: hold.
REQ-010 An increment from 999 SHALL produce 000, and enb_3 SHALL be a registered pulse that is high for exactly the one cycle following that increment.
REQ-011 enb_3 SHALL NOT assert on an rst_s clear, on a hold, or on reset release.
REQ-012 An increment from 999 while ch_ref=1 SHALL set a sticky ovf register.
REQ-013 The ovf register SHALL clear when rst_s=1 or ch_zr=1.
REQ-014 The block SHALL detect a falling edge of ld (ld registered 1, now 0) and on that edge SHALL load result from count; result SHALL hold at all other times.
REQ-015 If rst_s and the ld falling edge occur in the same cycle, result SHALL take the pre-clear count.
REQ-016 If ch_vm and ch_ref are both 1, ch_vm SHALL take priority in the integrator, and the counter SHALL behave as for ch_vm alone.
REQ-017 acc SHALL be wide enough for 1000 cycles of vin=255 (255000) without wrap; behaviour beyond that is unspecified.
REQ-018 The latency from a control input to acc, count and enb_3 SHALL be one clock; Vint_z SHALL follow acc with no additional latency.

Reset
REQ-019 On rst=1 the block SHALL immediately set:
- acc=0, count=000, result=000, ovf=0.
- enb_3=0, and the internal ld delay register to 0.
- Vint_z therefore 1.
REQ-020 Reset asserted mid-conversion SHALL abort it, and no result load SHALL occur on reset release even if ld was high before reset.

Configuration
REQ-021 Macro DS_OVERFLOW_EN SHALL control the overflow feature as follows:
- Defined: overflow = ovf, and a load with ovf=1 SHALL store result = 999 BCD (12'h999).
- Undefined: overflow is tied 0, ovf logic is absent, and result always takes the raw count.

Verification
REQ-022 Reset: assert rst mid-count -> count=000, acc=0, Vint_z=1, enb_3=0 immediately; no result change after release.
REQ-023 Wrap: rst_s pulse, then enb_0=1 with ch_vm=1 for 1000 cycles -> count passes 999->000, and enb_3 is high for exactly one cycle after the 1000th increment.
REQ-024 Full conversion: vin=100, vref=200.
- ch_zr, then ch_vm with enb_0 for 1000 cycles -> acc=100000.
- Then ch_ref with enb_0 -> Vint_z rises after 500 cycles and count freezes at 12'h500.
- ld falls -> result=12'h500, overflow=0.
REQ-025 Rounding: vin=1, vref=3 -> discharge takes ceil(1000/3)=334 cycles; result=12'h334.
REQ-026 Overflow: vin=250, vref=200 -> second wrap during ch_ref (enb_3 pulses), then count freezes at 12'h250.
- With DS_OVERFLOW_EN: overflow=1, result=12'h999.
- Without: overflow=0, result=12'h250.
REQ-027 Priority: ch_zr and ch_vm both high with enb_0=1 -> acc stays 0 and count increments.
